pc_branch_unit: RTL and testbench



---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_cond.sv | 35 +++
 rtl/pc_branch_unit.sv | 111 +++++++++++
 tb/tb_pc_branch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the PC/branch stage: funct3 codes,
// ALU flag bit positions and trap FSM state encoding.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_TRAP = 1'b1;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: funct3 plus {N,Z,C,V} of rs1-rs2
// to a single taken/not-taken condition.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       cond
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  // C is the no-borrow flag, so C=1 means rs1 >= rs2 unsigned
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = w_z;
      F3_BNE:  cond = ~w_z;
      F3_BLT:  cond = w_n ^ w_v;
      F3_BGE:  cond = ~(w_n ^ w_v);
      F3_BLTU: cond = ~w_c;
      F3_BGEU: cond = w_c;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC stage with branch/jump resolution and misaligned-target trap.
// Define BRANCH_STATS_EN to add saturating branch counters.
module pc_branch_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic [3:0]  flags,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        trap,
  output logic [31:0] mepc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
`endif
);

  logic        r_state;
  logic [31:0] r_pc;
  logic [31:0] r_mepc;
  logic        r_trap;

  logic        w_cond;
  logic        w_run;
  logic        w_xfer;
  logic        w_mis;
  logic [31:0] w_target;
  logic        w_unused;

  branch_cond u_cond (
    .funct3 (funct3),
    .flags  (flags),
    .cond   (w_cond)
  );

  assign w_unused = alu_result[0];
  assign w_run    = (r_state == ST_RUN);
  assign w_xfer   = jalr | jump | (branch & w_cond);
  assign taken    = en & w_run & w_xfer;
  assign w_target = jalr ? {alu_result[31:1], 1'b0}
                         : r_pc + imm;
  assign w_mis    = taken & (w_target[1:0] != 2'b00);
  assign pc_plus4 = r_pc + 32'd4;

  assign pc   = r_pc;
  assign trap = r_trap;
  assign mepc = r_mepc;

  // TRAP parks the PC at the handler until acked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_VECTOR;
      r_mepc  <= 32'd0;
      r_trap  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (en) begin
        if (w_mis) begin
          r_pc    <= TRAP_VECTOR;
          r_mepc  <= r_pc;
          r_trap  <= 1'b1;
          r_state <= ST_TRAP;
        end else if (taken) begin
          r_pc <= w_target;
        end else begin
          r_pc <= pc_plus4;
        end
      end
    end else if (trap_ack) begin
      r_state <= ST_RUN;
      r_trap  <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_br_taken_cnt;
  logic        w_br_commit;

  assign w_br_commit  = en & w_run & branch;
  assign br_cnt       = r_br_cnt;
  assign br_taken_cnt = r_br_taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt       <= 32'd0;
      r_br_taken_cnt <= 32'd0;
    end else if (w_br_commit) begin
      if (r_br_cnt != 32'hFFFF_FFFF)
        r_br_cnt <= r_br_cnt + 32'd1;
      if (w_cond && r_br_taken_cnt != 32'hFFFF_FFFF)
        r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit.
// Inputs change 1ns after rising edges; outputs sampled before the next.
module tb_pc_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        branch;
  logic        jump;
  logic        jalr;
  logic [2:0]  funct3;
  logic [3:0]  flags;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        trap;
  logic [31:0] mepc;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;
`endif

  int total;
  int bad;
  logic [31:0] exp_pc;

  pc_branch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .branch     (branch),
    .jump       (jump),
    .jalr       (jalr),
    .funct3     (funct3),
    .flags      (flags),
    .imm        (imm),
    .alu_result (alu_result),
    .trap_ack   (trap_ack),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .taken      (taken),
    .trap       (trap),
    .mepc       (mepc)
`ifdef BRANCH_STATS_EN
    ,
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; branch = 0; jump = 0; jalr = 0;
    funct3 = 0; flags = 0; imm = 0;
    alu_result = 0; trap_ack = 0;
  endtask

  // jump to an aligned target via pc+imm, tracked by exp_pc
  task automatic setpc(input logic [31:0] t);
    idle();
    en = 1; jump = 1; imm = t - exp_pc;
    step();
    idle();
    exp_pc = t;
    check("setpc", pc, t);
  endtask

  task automatic br(input logic [2:0] f3,
                    input logic [3:0] fl,
                    input logic [31:0] off,
                    input logic t_exp,
                    input string tag);
    idle();
    en = 1; branch = 1; funct3 = f3;
    flags = fl; imm = off;
    #1;
    check({tag, "_taken"}, {31'd0, taken}, {31'd0, t_exp});
    step();
    idle();
    exp_pc = t_exp ? exp_pc + off : exp_pc + 4;
    check({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    total = 0;
    bad = 0;
    idle();
    rst_n = 0;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_mepc", mepc, 32'h0);
    rst_n = 1;
    exp_pc = 0;

    en = 1;
    for (int i = 0; i < 16; i++) step();
    idle();
    check("run_pc40", pc, 32'h40);

    #2 rst_n = 0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_trap", {31'd0, trap}, 32'd0);
    step();
    rst_n = 1;
    en = 1;
    step(); check("post_rst1", pc, 32'h4);
    step(); check("post_rst2", pc, 32'h8);
    step(); check("post_rst3", pc, 32'hC);
    idle();
    exp_pc = 32'hC;

    setpc(32'h10);
    br(3'b000, 4'b0100, 32'h20, 1'b1, "beq_t");
    setpc(32'h10);
    br(3'b000, 4'b0000, 32'h20, 1'b0, "beq_nt");

    br(3'b100, 4'b1010, 32'h8, 1'b1, "blt");
    br(3'b110, 4'b1010, 32'h8, 1'b0, "bltu");
    br(3'b111, 4'b1010, 32'h10, 1'b1, "bgeu");
    br(3'b101, 4'b1010, 32'h8, 1'b0, "bge");
    br(3'b010, 4'b0100, 32'h8, 1'b0, "f3_010");
    br(3'b001, 4'b0000, 32'h8, 1'b1, "bne");

    setpc(32'h30);
    en = 1; jalr = 1; jump = 1; branch = 1;
    funct3 = 3'b000; flags = 4'b0100;
    imm = 32'h40; alu_result = 32'h0000_1235;
    #1;
    check("jalr_link", pc_plus4, 32'h34);
    check("jalr_taken", {31'd0, taken}, 32'd1);
    step();
    idle();
    check("jalr_pc", pc, 32'h1234);
    exp_pc = 32'h1234;

    setpc(32'h20);
    en = 1; jump = 1; imm = 32'h6;
    #1;
    check("mis_taken", {31'd0, taken}, 32'd1);
    step();
    idle();
    check("mis_pc", pc, 32'h100);
    check("mis_mepc", mepc, 32'h20);
    check("mis_trap", {31'd0, trap}, 32'd1);
    en = 1; jump = 1; imm = 32'h40;
    #1;
    check("trap_taken", {31'd0, taken}, 32'd0);
    step();
    check("trap_hold", pc, 32'h100);
    check("trap_still", {31'd0, trap}, 32'd1);
    trap_ack = 1;
    step();
    idle();
    check("ack_trap", {31'd0, trap}, 32'd0);
    check("ack_pc", pc, 32'h100);
    check("ack_mepc", mepc, 32'h20);
    en = 1;
    step();
    idle();
    check("after_ack", pc, 32'h104);

    en = 1; jalr = 1; alu_result = 32'h0000_1003;
    step();
    idle();
    check("jalr_mis_pc", pc, 32'h100);
    check("jalr_mis_mepc", mepc, 32'h104);
    trap_ack = 1;
    step();
    trap_ack = 1;
    step();
    idle();
    check("ack_run_trap", {31'd0, trap}, 32'd0);
    check("ack_run_pc", pc, 32'h100);
    exp_pc = 32'h100;

    setpc(32'hFFFF_FFFC);
    en = 1;
    step();
    idle();
    check("wrap", pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold", pc, 32'h0);
    end
    exp_pc = 0;

`ifdef BRANCH_STATS_EN
    rst_n = 0;
    #1;
    check("cnt_rst", br_cnt, 32'd0);
    step();
    rst_n = 1;
    exp_pc = 0;
    br(3'b000, 4'b0100, 32'h8, 1'b1, "s1");
    br(3'b000, 4'b0000, 32'h8, 1'b0, "s2");
    br(3'b001, 4'b0000, 32'h8, 1'b1, "s3");
    check("br_cnt", br_cnt, 32'd3);
    check("br_taken_cnt", br_taken_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
